sdram_arbiter: RTL and testbench

Two-master arbiter that shares the single Avalon-MM port of the SDRAM controller between the Nios II data master and a second bus master, e.g. a DMA engine. It sits between both masters and the controller's slave port. It grants the port round-robin with a bounded hold length and tracks outstanding reads in a tag FIFO, so that in-order read data is returned to the master that issued it.

---
 rtl/sdram_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_sdram_arbiter.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: shares one Avalon-MM SDRAM port between two masters.
// Round-robin grant with bounded hold; tag FIFO routes in-order read data.
module sdram_arbiter #(
    parameter int ADDR_W   = 22,
    parameter int DATA_W   = 16,
    parameter int MAX_PEND = 4,
    parameter int HOLD_MAX = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_W-1:0]     m0_address,
    input  logic                  m0_read,
    input  logic                  m0_write,
    input  logic [DATA_W-1:0]     m0_writedata,
    input  logic [DATA_W/8-1:0]   m0_byteenable,
    output logic                  m0_waitrequest,
    output logic [DATA_W-1:0]     m0_readdata,
    output logic                  m0_readdatavalid,
    input  logic [ADDR_W-1:0]     m1_address,
    input  logic                  m1_read,
    input  logic                  m1_write,
    input  logic [DATA_W-1:0]     m1_writedata,
    input  logic [DATA_W/8-1:0]   m1_byteenable,
    output logic                  m1_waitrequest,
    output logic [DATA_W-1:0]     m1_readdata,
    output logic                  m1_readdatavalid,
    output logic [ADDR_W-1:0]     s_address,
    output logic                  s_read,
    output logic                  s_write,
    output logic [DATA_W-1:0]     s_writedata,
    output logic [DATA_W/8-1:0]   s_byteenable,
    input  logic                  s_waitrequest,
    input  logic [DATA_W-1:0]     s_readdata,
    input  logic                  s_readdatavalid
);

    localparam int PW = $clog2(MAX_PEND + 1);
    localparam int AW = $clog2(MAX_PEND);
    localparam int HW = $clog2(HOLD_MAX + 1);
    localparam logic [PW-1:0] PEND_FULL = PW'(MAX_PEND);
    localparam logic [HW-1:0] HOLD_TOP  = HW'(HOLD_MAX);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_MAX - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_GRANT0 = 2'd1,
        S_GRANT1 = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic                  r_last;
    logic [HW-1:0]         r_hcnt;
    logic [PW-1:0]         r_pcnt;
    logic [AW-1:0]         r_wptr;
    logic [AW-1:0]         r_rptr;
    logic [MAX_PEND-1:0]   r_tag;

    logic w_req0;
    logic w_req1;
    logic w_full;
    logic w_accept;
    logic w_push;
    logic w_pop;
    logic w_head;
    logic w_free;
    logic w_hold_hit;

    assign w_req0     = m0_read | m0_write;
    assign w_req1     = m1_read | m1_write;
    assign w_full     = (r_pcnt == PEND_FULL);
    assign w_accept   = (s_read | s_write) & ~s_waitrequest;
    assign w_push     = s_read & ~s_waitrequest;
    assign w_pop      = s_readdatavalid & (r_pcnt != '0);
    assign w_head     = r_tag[r_rptr];
    // A held command must stay stable, so ownership may only move when
    // nothing is presented or the presented command is taken this cycle.
    assign w_free     = ~(s_read | s_write) | w_accept;
    assign w_hold_hit = (r_hcnt >= HOLD_LAST);

    assign m0_readdata      = s_readdata;
    assign m1_readdata      = s_readdata;
    assign m0_readdatavalid = w_pop & ~w_head;
    assign m1_readdatavalid = w_pop & w_head;

    // Command mux: forward the owner's command, stall everyone else.
    always_comb begin
        s_address      = '0;
        s_writedata    = '0;
        s_byteenable   = '0;
        s_read         = 1'b0;
        s_write        = 1'b0;
        m0_waitrequest = 1'b1;
        m1_waitrequest = 1'b1;
        unique case (r_state)
            S_GRANT0: begin
                s_address      = m0_address;
                s_writedata    = m0_writedata;
                s_byteenable   = m0_byteenable;
                s_write        = m0_write;
                s_read         = m0_read & ~w_full;
                m0_waitrequest = s_waitrequest | (m0_read & w_full);
            end
            S_GRANT1: begin
                s_address      = m1_address;
                s_writedata    = m1_writedata;
                s_byteenable   = m1_byteenable;
                s_write        = m1_write;
                s_read         = m1_read & ~w_full;
                m1_waitrequest = s_waitrequest | (m1_read & w_full);
            end
            default: begin
            end
        endcase
    end

    // Next-state: round-robin from idle, bounded hold while granted.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_req0 && w_req1) begin
                    w_next = r_last ? S_GRANT0 : S_GRANT1;
                end else if (w_req0) begin
                    w_next = S_GRANT0;
                end else if (w_req1) begin
                    w_next = S_GRANT1;
                end
            end
            S_GRANT0: begin
                if (w_free) begin
                    if (w_req1 && (!w_req0 || (w_accept && w_hold_hit))) begin
                        w_next = S_GRANT1;
                    end else if (!w_req0 && !w_req1) begin
                        w_next = S_IDLE;
                    end
                end
            end
            S_GRANT1: begin
                if (w_free) begin
                    if (w_req0 && (!w_req1 || (w_accept && w_hold_hit))) begin
                        w_next = S_GRANT0;
                    end else if (!w_req0 && !w_req1) begin
                        w_next = S_IDLE;
                    end
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Grant state, last owner and per-grant accept counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_last  <= 1'b1;
            r_hcnt  <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_GRANT0 && w_next != S_GRANT0) begin
                r_last <= 1'b0;
            end else if (r_state == S_GRANT1 && w_next != S_GRANT1) begin
                r_last <= 1'b1;
            end
            if (w_next != r_state) begin
                r_hcnt <= '0;
            end else if (w_accept && r_hcnt != HOLD_TOP) begin
                r_hcnt <= r_hcnt + HW'(1);
            end
        end
    end

    // Tag FIFO: one entry per accepted read, popped by returning data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tag  <= '0;
            r_wptr <= '0;
            r_rptr <= '0;
            r_pcnt <= '0;
        end else begin
            if (w_push) begin
                r_tag[r_wptr] <= (r_state == S_GRANT1);
                r_wptr        <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            unique case ({w_push, w_pop})
                2'b10:   r_pcnt <= r_pcnt + PW'(1);
                2'b01:   r_pcnt <= r_pcnt - PW'(1);
                default: r_pcnt <= r_pcnt;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter: directed checks of grant, fairness, read routing,
// tag FIFO backpressure, stall stability and reset behaviour.
module tb_sdram_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [21:0] m0_address, m1_address, s_address;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [15:0] m0_writedata, m1_writedata, s_writedata;
    logic [1:0]  m0_byteenable, m1_byteenable, s_byteenable;
    logic        m0_waitrequest, m1_waitrequest;
    logic [15:0] m0_readdata, m1_readdata, s_readdata;
    logic        m0_readdatavalid, m1_readdatavalid;
    logic        s_read, s_write, s_waitrequest, s_readdatavalid;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sdram_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
        .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
        .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
        .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
        .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
        .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
        .m1_readdatavalid(m1_readdatavalid),
        .s_address(s_address), .s_read(s_read), .s_write(s_write),
        .s_writedata(s_writedata), .s_byteenable(s_byteenable),
        .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
        .s_readdatavalid(s_readdatavalid)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_in();
        m0_address = '0; m0_read = 0; m0_write = 0;
        m0_writedata = '0; m0_byteenable = '0;
        m1_address = '0; m1_read = 0; m1_write = 0;
        m1_writedata = '0; m1_byteenable = '0;
        s_waitrequest = 0; s_readdata = '0; s_readdatavalid = 0;
    endtask

    task automatic do_reset();
        idle_in();
        rst_n = 0;
        tick();
        tick();
        rst_n = 1;
        tick();
    endtask

    task automatic test_reset();
        tick();
        tick();
        checks++;
        if ({m0_waitrequest, m1_waitrequest} !== 2'b11) begin
            failures++;
            $display("FAIL rst_wait got=%b exp=11", {m0_waitrequest, m1_waitrequest});
        end
        checks++;
        if ({s_read, s_write, m0_readdatavalid, m1_readdatavalid} !== 4'b0) begin
            failures++;
            $display("FAIL rst_cmd got=%b exp=0000",
                {s_read, s_write, m0_readdatavalid, m1_readdatavalid});
        end
        checks++;
        if (s_address !== 22'h0) begin
            failures++;
            $display("FAIL rst_addr got=%h exp=0", s_address);
        end
        rst_n = 1;
        tick();
        m0_write = 1; m0_address = 22'h5;
        settle();
        checks++;
        if (s_write !== 1'b0) begin
            failures++;
            $display("FAIL rst_idle_wr got=%b exp=0", s_write);
        end
        tick();
        checks++;
        if ({s_write, m0_waitrequest} !== 2'b10) begin
            failures++;
            $display("FAIL rst_grant got=%b exp=10", {s_write, m0_waitrequest});
        end
        #2;
        rst_n = 0;
        #1;
        checks++;
        if ({m0_waitrequest, m1_waitrequest, s_write, s_read} !== 4'b1100) begin
            failures++;
            $display("FAIL rst_async got=%b exp=1100",
                {m0_waitrequest, m1_waitrequest, s_write, s_read});
        end
        idle_in();
        tick();
        rst_n = 1;
        tick();
    endtask

    task automatic test_single();
        m0_write = 1; m0_address = 22'h10; m0_writedata = 16'h1000;
        m0_byteenable = 2'b11;
        settle();
        checks++;
        if (s_write !== 1'b0) begin
            failures++;
            $display("FAIL single_lat got=%b exp=0", s_write);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            m0_address = 22'h10 + 22'(i);
            m0_writedata = 16'h1000 + 16'(i);
            settle();
            checks++;
            if ({s_write, m0_waitrequest, m1_waitrequest} !== 3'b101 ||
                s_address !== 22'h10 + 22'(i) ||
                s_writedata !== 16'h1000 + 16'(i)) begin
                failures++;
                $display("FAIL single_wr%0d got=%b/%h/%h exp=101/%h/%h", i,
                    {s_write, m0_waitrequest, m1_waitrequest}, s_address,
                    s_writedata, 22'h10 + 22'(i), 16'h1000 + 16'(i));
            end
        end
        tick();
        m0_write = 0;
        settle();
        checks++;
        if (s_write !== 1'b0) begin
            failures++;
            $display("FAIL single_end got=%b exp=0", s_write);
        end
        tick();
        checks++;
        if (m0_waitrequest !== 1'b1) begin
            failures++;
            $display("FAIL single_idle got=%b exp=1", m0_waitrequest);
        end
    endtask

    task automatic test_fairness();
        int own;
        int exp_own;
        logic [21:0] exp_addr;
        do_reset();
        m0_write = 1; m0_address = 22'h0A;
        m1_write = 1; m1_address = 22'h0B;
        settle();
        for (int c = 0; c <= 32; c++) begin
            if (c > 0) begin
                tick();
            end
            own = !m0_waitrequest ? 0 : (!m1_waitrequest ? 1 : 2);
            exp_own = (c == 0) ? 2 : ((c - 1) / 8) % 2;
            exp_addr = (exp_own == 0) ? 22'h0A : (exp_own == 1) ? 22'h0B : 22'h0;
            checks++;
            if (own !== exp_own || s_address !== exp_addr) begin
                failures++;
                $display("FAIL fair_c%0d owner=%0d addr=%h exp owner=%0d addr=%h",
                    c, own, s_address, exp_own, exp_addr);
            end
        end
        tick();
        idle_in();
        tick();
        tick();
    endtask

    task automatic test_read_routing();
        m0_read = 1; m0_address = 22'h100;
        settle();
        tick();
        checks++;
        if ({s_read, m0_waitrequest} !== 2'b10 || s_address !== 22'h100) begin
            failures++;
            $display("FAIL rd_m0_cmd got=%b/%h exp=10/100", {s_read, m0_waitrequest}, s_address);
        end
        tick();
        m0_read = 0; m1_read = 1; m1_address = 22'h200;
        settle();
        checks++;
        if ({s_read, m1_waitrequest} !== 2'b01) begin
            failures++;
            $display("FAIL rd_m1_wait got=%b exp=01", {s_read, m1_waitrequest});
        end
        tick();
        checks++;
        if ({s_read, m1_waitrequest} !== 2'b10 || s_address !== 22'h200) begin
            failures++;
            $display("FAIL rd_m1_cmd got=%b/%h exp=10/200", {s_read, m1_waitrequest}, s_address);
        end
        tick();
        m1_read = 0; s_readdatavalid = 1; s_readdata = 16'hAAAA;
        settle();
        checks++;
        if ({m0_readdatavalid, m1_readdatavalid} !== 2'b10 || m0_readdata !== 16'hAAAA) begin
            failures++;
            $display("FAIL rd_ret0 got=%b/%h exp=10/aaaa",
                {m0_readdatavalid, m1_readdatavalid}, m0_readdata);
        end
        tick();
        s_readdatavalid = 0;
        settle();
        checks++;
        if ({m0_readdatavalid, m1_readdatavalid} !== 2'b00) begin
            failures++;
            $display("FAIL rd_gap got=%b exp=00", {m0_readdatavalid, m1_readdatavalid});
        end
        tick();
        s_readdatavalid = 1; s_readdata = 16'h5555;
        settle();
        checks++;
        if ({m0_readdatavalid, m1_readdatavalid} !== 2'b01 || m1_readdata !== 16'h5555) begin
            failures++;
            $display("FAIL rd_ret1 got=%b/%h exp=01/5555",
                {m0_readdatavalid, m1_readdatavalid}, m1_readdata);
        end
        tick();
        s_readdatavalid = 0;
        tick();
    endtask

    task automatic test_fifo_full();
        m0_read = 1; m0_address = 22'h300;
        settle();
        for (int i = 0; i < 4; i++) begin
            tick();
            m0_address = 22'h300 + 22'(i);
            settle();
            checks++;
            if ({s_read, m0_waitrequest} !== 2'b10 || s_address !== 22'h300 + 22'(i)) begin
                failures++;
                $display("FAIL full_acc%0d got=%b/%h exp=10/%h", i,
                    {s_read, m0_waitrequest}, s_address, 22'h300 + 22'(i));
            end
        end
        tick();
        m0_address = 22'h304;
        settle();
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({s_read, m0_waitrequest} !== 2'b01) begin
                failures++;
                $display("FAIL full_stall%0d got=%b exp=01", i, {s_read, m0_waitrequest});
            end
            tick();
        end
        s_readdatavalid = 1; s_readdata = 16'h0001;
        settle();
        checks++;
        if ({m0_readdatavalid, s_read, m0_waitrequest} !== 3'b101) begin
            failures++;
            $display("FAIL full_pop got=%b exp=101", {m0_readdatavalid, s_read, m0_waitrequest});
        end
        tick();
        s_readdatavalid = 0;
        settle();
        checks++;
        if ({s_read, m0_waitrequest} !== 2'b10 || s_address !== 22'h304) begin
            failures++;
            $display("FAIL full_5th got=%b/%h exp=10/304", {s_read, m0_waitrequest}, s_address);
        end
        tick();
        m0_read = 0;
        for (int i = 0; i < 5; i++) begin
            s_readdatavalid = 1;
            settle();
            checks++;
            if (m0_readdatavalid !== (i < 4)) begin
                failures++;
                $display("FAIL full_drain%0d got=%b exp=%b", i, m0_readdatavalid, (i < 4));
            end
            tick();
        end
        s_readdatavalid = 0;
        tick();
    endtask

    task automatic test_stall_reset();
        m0_write = 1; m0_address = 22'h2AA; m0_writedata = 16'hBEEF;
        m0_byteenable = 2'b11; s_waitrequest = 1;
        settle();
        tick();
        m1_write = 1; m1_address = 22'h155;
        settle();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (s_address !== 22'h2AA || {s_write, m0_waitrequest, m1_waitrequest} !== 3'b111) begin
                failures++;
                $display("FAIL stall%0d got=%h/%b exp=2aa/111", i,
                    s_address, {s_write, m0_waitrequest, m1_waitrequest});
            end
            tick();
        end
        s_waitrequest = 0;
        settle();
        checks++;
        if (s_address !== 22'h2AA || s_writedata !== 16'hBEEF ||
            s_byteenable !== 2'b11 || {s_write, m0_waitrequest} !== 2'b10) begin
            failures++;
            $display("FAIL stall_acc got=%h/%h/%b/%b exp=2aa/beef/11/10",
                s_address, s_writedata, s_byteenable, {s_write, m0_waitrequest});
        end
        tick();
        m0_write = 0;
        settle();
        checks++;
        if (m1_waitrequest !== 1'b1) begin
            failures++;
            $display("FAIL stall_m1wait got=%b exp=1", m1_waitrequest);
        end
        tick();
        checks++;
        if (s_address !== 22'h155 || m1_waitrequest !== 1'b0) begin
            failures++;
            $display("FAIL stall_sw got=%h/%b exp=155/0", s_address, m1_waitrequest);
        end
        idle_in();
        tick();
        tick();
        m0_read = 1; m0_address = 22'h10;
        settle();
        tick();
        checks++;
        if (s_read !== 1'b1) begin
            failures++;
            $display("FAIL prst_rd0 got=%b exp=1", s_read);
        end
        tick();
        m0_address = 22'h11;
        settle();
        checks++;
        if (s_read !== 1'b1) begin
            failures++;
            $display("FAIL prst_rd1 got=%b exp=1", s_read);
        end
        tick();
        m0_read = 0;
        #2;
        rst_n = 0;
        #1;
        tick();
        rst_n = 1;
        for (int i = 0; i < 2; i++) begin
            s_readdatavalid = 1; s_readdata = 16'h1234;
            settle();
            checks++;
            if ({m0_readdatavalid, m1_readdatavalid} !== 2'b00) begin
                failures++;
                $display("FAIL prst_stray%0d got=%b exp=00", i,
                    {m0_readdatavalid, m1_readdatavalid});
            end
            tick();
        end
        s_readdatavalid = 0;
        tick();
    endtask

    initial begin
        idle_in();
        test_reset();
        test_single();
        test_fairness();
        test_read_routing();
        test_fifo_full();
        test_stall_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
